instr_fetch: RTL and testbench

- Fetch stage sitting directly downstream of pc: takes the current instruction address (pc.RegPC) and reads the instruction word over the Avalon-style memory master interface.
- Holds the fetched word in an instruction register that drives the Instruction inputs of pc, the decoder and the register file.
- Detects the halt condition (fetch from address 0) and misaligned fetches.
- Is paced by the multicycle controller through a fetch_req/instr_valid handshake.

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: controller handshake, pc address and the
// Avalon-style read master. The fetch unit is the bus master.
interface instr_fetch_if;
    logic [31:0] pc_in;
    logic        fetch_req;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        busy;
    logic        addr_error;
    logic        active;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        input  pc_in, fetch_req, mem_waitrequest, mem_readdata,
        output instr_out, instr_valid, busy, addr_error, active,
               mem_address, mem_read, mem_byteenable
    );

    modport slave (
        output pc_in, fetch_req, mem_waitrequest, mem_readdata,
        input  instr_out, instr_valid, busy, addr_error, active,
               mem_address, mem_read, mem_byteenable
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the word at pc over the memory bus, holds it
// in the instruction register, and flags halt (fetch from 0) and misaligned pc.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter bit          BYTE_SWAP    = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HALT} state_t;

    // Little-endian bus word to big-endian MIPS instruction.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic        instr_valid_q;
    logic        addr_error_q;
    logic        busy_q;
    logic        active_q;
    logic        mem_read_q;

    // Word that the instruction register captures in the DATA cycle.
    always_comb begin
        instr_d = BYTE_SWAP ? swap_bytes(bus.mem_readdata) : bus.mem_readdata;
    end

    // Fetch FSM; every output is registered so the bus sees clean strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= RESET_VECTOR;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            addr_error_q  <= 1'b0;
            busy_q        <= 1'b0;
            active_q      <= 1'b1;
            mem_read_q    <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            addr_error_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.fetch_req) begin
                        if (bus.pc_in == 32'h0) begin
                            state_q  <= S_HALT;
                            active_q <= 1'b0;
                        end else if (bus.pc_in[1:0] != 2'b00) begin
                            addr_error_q <= 1'b1;
                        end else begin
                            addr_q     <= bus.pc_in;
                            mem_read_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // Hold address and strobe until the slave stops stalling.
                    if (!bus.mem_waitrequest) begin
                        mem_read_q <= 1'b0;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    instr_q       <= instr_d;
                    instr_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                S_HALT: begin
                    // Terminal until reset.
                    state_q  <= S_HALT;
                    active_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_out      = instr_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.busy           = busy_q;
    assign bus.addr_error     = addr_error_q;
    assign bus.active         = active_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_byteenable = mem_read_q ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scenario tasks with a queue of expected instruction
// words pushed when read data is driven and popped when instr_valid fires.
module tb_instr_fetch;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_q[$];

    instr_fetch_if bus ();

    instr_fetch #(.RESET_VECTOR(32'hBFC00000), .BYTE_SWAP(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample/drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h want=%h", bus.instr_out, 32'h0); end
        n_tests++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL rst_active got=%b want=1", bus.active); end
        n_tests++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_memread got=%b want=0", bus.mem_read); end
        n_tests++; if (bus.mem_address !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_addr got=%h want=%h", bus.mem_address, 32'hBFC00000); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        n_tests++; if (bus.instr_valid !== 1'b0 || bus.addr_error !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got=%b%b want=00", bus.instr_valid, bus.addr_error); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        bus.pc_in = 32'hBFC00000;
        bus.fetch_req = 1'b1;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata = 32'hDEADBEEF;
        tick();                                   // cycle k+1: ADDR
        bus.fetch_req = 1'b0;
        n_tests++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL zw_read_k1 got=%b want=1", bus.mem_read); end
        n_tests++; if (bus.mem_address !== 32'hBFC00000) begin n_fail++; $display("FAIL zw_addr got=%h want=%h", bus.mem_address, 32'hBFC00000); end
        n_tests++; if (bus.mem_byteenable !== 4'hF || bus.busy !== 1'b1) begin n_fail++; $display("FAIL zw_be_busy got=%h/%b want=f/1", bus.mem_byteenable, bus.busy); end
        tick();                                   // cycle k+2: DATA
        bus.mem_readdata = 32'h0500A110;
        exp_q.push_back(32'h10A10005);
        n_tests++; if (bus.mem_read !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL zw_data got=%b/%b want=0/1", bus.mem_read, bus.busy); end
        n_tests++; if (bus.mem_byteenable !== 4'h0) begin n_fail++; $display("FAIL zw_be_idle got=%h want=0", bus.mem_byteenable); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_early_valid got=%b want=0", bus.instr_valid); end
        tick();                                   // cycle k+3
        bus.mem_readdata = 32'hDEADBEEF;
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid got=%b want=1", bus.instr_valid); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        n_tests++; if (bus.instr_out !== e) begin n_fail++; $display("FAIL zw_instr got=%h want=%h", bus.instr_out, e); end
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'h10A10005) begin n_fail++; $display("FAIL zw_hold got=%b/%h want=0/10a10005", bus.instr_valid, bus.instr_out); end
    endtask

    task automatic test_wait_states();
        logic [31:0] e;
        bus.pc_in = 32'hBFC00004;
        bus.fetch_req = 1'b1;
        bus.mem_waitrequest = 1'b1;
        tick();                                   // cycle k+1: ADDR
        bus.fetch_req = 1'b0;
        bus.pc_in = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'hBFC00004) begin n_fail++; $display("FAIL ws_stable[%0d] got=%b/%h want=1/bfc00004", i, bus.mem_read, bus.mem_address); end
            if (i == 3) bus.mem_waitrequest = 1'b0;
            tick();
        end
        // cycle k+5: DATA
        bus.mem_readdata = 32'h78563412;
        exp_q.push_back(32'h12345678);
        n_tests++; if (bus.mem_read !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL ws_data got=%b/%b want=0/0", bus.mem_read, bus.instr_valid); end
        tick();                                   // cycle k+6
        bus.mem_readdata = 32'hDEADBEEF;
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid got=%b want=1", bus.instr_valid); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        n_tests++; if (bus.instr_out !== e) begin n_fail++; $display("FAIL ws_instr got=%h want=%h", bus.instr_out, e); end
        n_tests++; if (bus.active !== 1'b1 || bus.mem_address !== 32'hBFC00004) begin n_fail++; $display("FAIL ws_pc_ignored got=%b/%h want=1/bfc00004", bus.active, bus.mem_address); end
        tick();
    endtask

    task automatic test_misaligned();
        bus.pc_in = 32'hBFC00002;
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        n_tests++; if (bus.addr_error !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%b want=1", bus.addr_error); end
        n_tests++; if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mis_nobus got=%b/%b want=0/0", bus.mem_read, bus.busy); end
        n_tests++; if (bus.instr_out !== 32'h12345678) begin n_fail++; $display("FAIL mis_instr got=%h want=12345678", bus.instr_out); end
        tick();
        n_tests++; if (bus.addr_error !== 1'b0 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got=%b/%b want=0/0", bus.addr_error, bus.mem_read); end
    endtask

    task automatic test_halt();
        bus.pc_in = 32'h0;
        bus.fetch_req = 1'b1;
        tick();
        n_tests++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL halt_active got=%b want=0", bus.active); end
        n_tests++; if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_nobus got=%b/%b want=0/0", bus.mem_read, bus.busy); end
        bus.pc_in = 32'hBFC00000;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (bus.mem_read !== 1'b0 || bus.active !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_ignore[%0d] got=%b/%b/%b want=0/0/0", i, bus.mem_read, bus.active, bus.instr_valid); end
        end
        bus.fetch_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL halt_reset got=%b want=1", bus.active); end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        bus.pc_in = 32'hBFC00008;
        bus.fetch_req = 1'b1;
        bus.mem_waitrequest = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        n_tests++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_read got=%b want=1", bus.mem_read); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata = 32'hAABBCCDD;
        n_tests++; if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_drop got=%b/%b want=0/0", bus.mem_read, bus.busy); end
        n_tests++; if (bus.instr_out !== 32'h0 || bus.mem_address !== 32'hBFC00000) begin n_fail++; $display("FAIL rmid_regs got=%h/%h want=0/bfc00000", bus.instr_out, bus.mem_address); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL rmid_novalid[%0d] got=%b/%h want=0/0", i, bus.instr_valid, bus.instr_out); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        bus.pc_in = 32'hBFC00010;
        bus.fetch_req = 1'b1;
        bus.mem_waitrequest = 1'b0;
        tick();                                   // k+1 ADDR (req held, ignored)
        tick();                                   // k+2 DATA
        bus.mem_readdata = 32'h44332211;
        exp_q.push_back(32'h11223344);
        bus.pc_in = 32'hBFC00014;
        tick();                                   // k+3 valid, new fetch accepted
        bus.mem_readdata = 32'hDEADBEEF;
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1 got=%b want=1", bus.instr_valid); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        n_tests++; if (bus.instr_out !== e) begin n_fail++; $display("FAIL b2b_instr1 got=%h want=%h", bus.instr_out, e); end
        tick();                                   // k+4 ADDR of second fetch
        bus.fetch_req = 1'b0;
        n_tests++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'hBFC00014) begin n_fail++; $display("FAIL b2b_addr2 got=%b/%h want=1/bfc00014", bus.mem_read, bus.mem_address); end
        tick();                                   // k+5 DATA
        bus.mem_readdata = 32'h0000FF01;
        exp_q.push_back(32'h01FF0000);
        tick();                                   // k+6
        bus.mem_readdata = 32'hDEADBEEF;
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2 got=%b want=1", bus.instr_valid); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        n_tests++; if (bus.instr_out !== e) begin n_fail++; $display("FAIL b2b_instr2 got=%h want=%h", bus.instr_out, e); end
        tick();
        n_tests++; if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b/%b want=0/0", bus.mem_read, bus.busy); end
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_empty got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.pc_in = 32'h0;
        bus.fetch_req = 1'b0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_misaligned();
        test_halt();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
